median_delay_var: RTL and testbench
===================================

# median_delay_var

Runtime-selectable, valid-tracking delay line for the median filter pipeline. Data words are delayed by a programmable number of clock-enabled cycles, from 0 to MAX_DELAY. A valid flag travels with each word. A fill state machine suppresses the output valid while the line refills after reset or after a delay change. Typical use is aligning pixel data and sync/valid flags with the latency of the median sorting network when the window size changes at runtime.

## Interface
- N, 5: data width in bits.
- MAX_DELAY, 8: number of physical stages; must be ≥ 1.
- DEFAULT_DELAY, 5: delay loaded at reset; must be ≤ MAX_DELAY.
- DW, $clog2(MAX_DELAY+1): width of the delay select; localparam.

Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: synchronous reset, active-high.
- ce, in, 1: clock enable; when low, all state holds.
- dsel, in, DW: requested delay D; values above MAX_DELAY clamp to MAX_DELAY.
- idata, in, N: input data word.
- ivalid, in, 1: qualifies idata.
- odata, out, N: delayed data.
- ovalid, out, 1: qualifies odata; only asserted when the line is primed.
- primed, out, 1: high in the RUN state.

## Operation
- Storage consists of stages s[1..MAX_DELAY], each holding N data bits plus 1 valid bit.
- On each edge where ce=1:
  - s[1] ← {ivalid, idata}.
  - s[j] ← s[j-1] for j ≥ 2.
- Active delay dr is a register. dsel is clamped, then sampled only on ce=1 edges.
- Output tap:
  - dr=0: odata=idata, ovalid=ivalid & primed (combinational pass-through).
  - otherwise: odata=s[dr].data, ovalid=s[dr].valid & primed.
- Fill counter cnt, width DW, counts ce=1 edges and saturates at dr.
- FSM states are FILL and RUN. primed = (state==RUN).
  - FILL→RUN: on the ce edge where cnt+1 ≥ dr. For dr=0 the transition happens on the first ce edge.
  - RUN→FILL: on any ce edge where clamp(dsel) ≠ dr.
    - On that edge: dr ← clamp(dsel), cnt ← 0, state ← FILL.
    - The shift still happens on that edge.
  - FILL with another dsel change: dr is reloaded and cnt restarts from 0.
- Stage contents are never cleared by a delay change. Stale words are masked only through primed.
- Reset values, with rst winning over ce:
  - all s[j] data and valid bits = 0
  - dr = DEFAULT_DELAY
  - cnt = 0
  - state = FILL
  - odata = 0 (dr>0) or idata (dr=0)
  - ovalid = 0
  - primed = 0
- Reset asserted mid-stream discards all in-flight words. The line must refill for dr ce edges before ovalid can rise.

## Timing
- Latency is exactly dr ce-qualified edges.
  - A word presented on ce edge t appears on odata after ce edge t+dr-1.
  - That is, it is visible in the cycle following the dr-th ce edge, counting edge t as the first.
- With ce=1 continuously and dr=D: input in cycle k appears on odata in cycle k+D.
- Cycles with ce=0 do not count. Outputs, counter, FSM and dr all hold.
- After reset or after a delay change to D>0, primed rises after exactly D ce edges.
  - The first ovalid=1 word is the first word accepted after the change/reset, delayed by D.
- dsel changes while ce=0 are ignored until the next ce=1 edge.
- Back-to-back ce with rst=1: no shift occurs.

## Configuration
- MEDIAN_DELAY_VAR_OREG_EN defined:
  - odata and ovalid come from an output register updated on ce=1 edges from the tap above.
  - Total latency is dr+1, so dr=0 gives 1.
  - The register resets to 0.
  - primed is unchanged and is not registered.
- Not defined: outputs are combinational from the tap mux, latency dr, behaviour as above.

## Test plan
- Reset, dsel=5 constant, ce=1, ivalid=1, idata=1,2,3… → odata/ovalid=0 for 5 cycles, then odata=1,2,3… with ovalid=1. primed rises with the first valid output.
- ce toggled 1,0,1,0 with dsel=3 → exactly 3 ce-high edges per word of latency. Outputs frozen during ce=0.
- Running at D=5, change dsel to 2 → ovalid drops for 2 ce edges, then the data stream resumes at latency 2 with no duplicated ovalid word.
- dsel=0 → odata=idata the same cycle, ovalid=ivalid after the first ce edge. dsel=15 with MAX_DELAY=8 → behaves as D=8.
- rst asserted for 1 cycle mid-stream at D=4 → all outputs 0 next cycle, dr=DEFAULT_DELAY, 5 ce edges before ovalid returns. Repeat with MEDIAN_DELAY_VAR_OREG_EN → every latency is +1.
- ivalid pattern 1,0,1,1 at D=3 → ovalid reproduces 1,0,1,1 shifted by 3 cycles once primed.

Source files
------------

// File: rtl/median_delay_var.sv
// Programmable delay line (0..MAX_DELAY ce-qualified cycles) with a travelling valid bit and a
// fill FSM that masks ovalid until the line has refilled. Build option: MEDIAN_DELAY_VAR_OREG_EN.
module median_delay_var #(
  parameter int unsigned N             = 5,
  parameter int unsigned MAX_DELAY     = 8,
  parameter int unsigned DEFAULT_DELAY = 5,
  localparam int unsigned DW           = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ce_i,
  input  logic [DW-1:0] dsel_i,
  input  logic [N-1:0]  idata_i,
  input  logic          ivalid_i,
  output logic [N-1:0]  odata_o,
  output logic          ovalid_o,
  output logic          primed_o
);

  typedef enum logic {StFill, StRun} state_e;

  state_e        state_q;
  logic [DW-1:0] dr_q;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] dsel_clamped;
  logic [DW:0]   cnt_inc;
  logic [N:0]    stage_q [MAX_DELAY];
  logic [N:0]    tap;
  logic          primed;

  assign dsel_clamped = (dsel_i > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : dsel_i;
  assign cnt_inc      = {1'b0, cnt_q} + (DW + 1)'(1);
  assign primed       = (state_q == StRun);
  assign primed_o     = primed;

  // Delay change restarts the fill count; stage contents stay and are masked via primed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFill;
      dr_q    <= DW'(DEFAULT_DELAY);
      cnt_q   <= '0;
    end else if (ce_i) begin
      if (dsel_clamped != dr_q) begin
        state_q <= StFill;
        dr_q    <= dsel_clamped;
        cnt_q   <= '0;
      end else begin
        if (cnt_q < dr_q) cnt_q <= cnt_inc[DW-1:0];
        if ((state_q == StFill) && (cnt_inc >= {1'b0, dr_q})) state_q <= StRun;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned j = 0; j < MAX_DELAY; j++) stage_q[j] <= '0;
    end else if (ce_i) begin
      stage_q[0] <= {ivalid_i, idata_i};
      for (int unsigned j = 1; j < MAX_DELAY; j++) stage_q[j] <= stage_q[j-1];
    end
  end

  // dr_q == 0 selects the live input; otherwise stage dr_q (stored at index dr_q-1).
  always_comb begin
    tap = {ivalid_i, idata_i};
    for (int unsigned j = 0; j < MAX_DELAY; j++) begin
      if (dr_q == DW'(j + 1)) tap = stage_q[j];
    end
  end

`ifdef MEDIAN_DELAY_VAR_OREG_EN
  logic [N-1:0] odata_q;
  logic         ovalid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      odata_q  <= '0;
      ovalid_q <= 1'b0;
    end else if (ce_i) begin
      odata_q  <= tap[N-1:0];
      ovalid_q <= tap[N] & primed;
    end
  end

  assign odata_o  = odata_q;
  assign ovalid_o = ovalid_q;
`else
  assign odata_o  = tap[N-1:0];
  assign ovalid_o = tap[N] & primed;
`endif

endmodule

// File: tb/tb_median_delay_var.sv
// Directed bench for median_delay_var (N=5, MAX_DELAY=8, DEFAULT_DELAY=5); expected values are
// written for the tap outputs and passed through an output-register model when OREG is enabled.
module tb_median_delay_var;

`ifdef MEDIAN_DELAY_VAR_OREG_EN
  localparam bit OregEn = 1'b1;
`else
  localparam bit OregEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, ce, ivalid;
  logic [3:0] dsel;
  logic [4:0] idata;
  logic [4:0] odata;
  logic       ovalid, primed;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the optional output register: holds the tap value of the last ce edge.
  logic [4:0] oq_d  = '0;
  logic       oq_v  = 1'b0;
  logic       oq_cd = 1'b1;

  median_delay_var #(
    .N             (5),
    .MAX_DELAY     (8),
    .DEFAULT_DELAY (5)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .ce_i     (ce),
    .dsel_i   (dsel),
    .idata_i  (idata),
    .ivalid_i (ivalid),
    .odata_o  (odata),
    .ovalid_o (ovalid),
    .primed_o (primed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs, check tap-level expectations (ed/ev/ep), then clock.
  // cd=0 skips the data check where the line holds stale words.
  task automatic tick(input logic r, input logic c, input logic [3:0] ds, input logic [4:0] d,
                      input logic v, input logic [4:0] ed, input logic ev, input logic ep,
                      input logic cd, input string tag);
    rst = r; ce = c; dsel = ds; idata = d; ivalid = v;
    #1;
    if (OregEn) begin
      if (oq_cd) check({tag, ".odata"}, 32'(odata), 32'(oq_d));
      check({tag, ".ovalid"}, 32'(ovalid), 32'(oq_v));
    end else begin
      if (cd) check({tag, ".odata"}, 32'(odata), 32'(ed));
      check({tag, ".ovalid"}, 32'(ovalid), 32'(ev));
    end
    check({tag, ".primed"}, 32'(primed), 32'(ep));
    if (r) begin
      oq_d = '0; oq_v = 1'b0; oq_cd = 1'b1;
    end else if (c) begin
      oq_d = ed; oq_v = ev; oq_cd = cd;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; dsel = 4'd5; idata = '0; ivalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tick(1, 1, 5, 0, 0, 0, 0, 0, 1, "reset");

    // Fill at D=5: five masked cycles, then word k-5.
    for (int k = 1; k <= 12; k++) begin
      if (k <= 5) tick(0, 1, 5, 5'(k), 1, 0, 0, 0, 1, "fill5");
      else        tick(0, 1, 5, 5'(k), 1, 5'(k - 5), 1, 1, 1, "run5");
    end

    // Shrink to D=2: two masked edges, resume at latency 2.
    tick(0, 1, 2, 13, 1, 8, 1, 1, 1, "chg2_edge");
    tick(0, 1, 2, 14, 1, 12, 0, 0, 1, "chg2_fill_a");
    tick(0, 1, 2, 15, 1, 13, 0, 0, 1, "chg2_fill_b");
    for (int k = 16; k <= 20; k++) tick(0, 1, 2, 5'(k), 1, 5'(k - 2), 1, 1, 1, "run2");

    // D=3 with ce toggling; dsel=7 during a ce=0 cycle must be ignored.
    tick(0, 1, 3, 21, 1, 19, 1, 1, 1, "ce_chg3");
    tick(0, 0, 3, 31, 0, 19, 0, 0, 1, "ce_hold_a");
    tick(0, 1, 3, 22, 1, 19, 0, 0, 1, "ce_fill_a");
    tick(0, 0, 3, 31, 0, 20, 0, 0, 1, "ce_hold_b");
    tick(0, 1, 3, 23, 1, 20, 0, 0, 1, "ce_fill_b");
    tick(0, 0, 3, 31, 0, 21, 0, 0, 1, "ce_hold_c");
    tick(0, 1, 3, 24, 1, 21, 0, 0, 1, "ce_fill_c");
    tick(0, 0, 3, 31, 0, 22, 1, 1, 1, "ce_prime");
    tick(0, 1, 3, 25, 1, 22, 1, 1, 1, "ce_run_a");
    tick(0, 0, 7, 31, 0, 23, 1, 1, 1, "ce_dsel_ign");
    tick(0, 1, 3, 26, 1, 23, 1, 1, 1, "ce_run_b");
    tick(0, 0, 3, 31, 0, 24, 1, 1, 1, "ce_run_c");

    // ivalid pattern 1,0,1,1 reproduced 3 cycles later.
    tick(0, 1, 3, 1, 1, 24, 1, 1, 1, "vpat_1");
    tick(0, 1, 3, 2, 0, 25, 1, 1, 1, "vpat_2");
    tick(0, 1, 3, 3, 1, 26, 1, 1, 1, "vpat_3");
    tick(0, 1, 3, 4, 1, 1, 1, 1, 1, "vpat_4");
    tick(0, 1, 3, 0, 0, 2, 0, 1, 1, "vpat_5");
    tick(0, 1, 3, 0, 0, 3, 1, 1, 1, "vpat_6");
    tick(0, 1, 3, 0, 0, 4, 1, 1, 1, "vpat_7");
    tick(0, 1, 3, 0, 0, 0, 0, 1, 1, "vpat_8");

    // D=0 pass-through; primed after the first ce edge, held through ce=0.
    tick(0, 1, 0, 9, 1, 0, 0, 1, 1, "d0_edge");
    tick(0, 1, 0, 10, 1, 10, 0, 0, 1, "d0_fill");
    tick(0, 1, 0, 11, 1, 11, 1, 1, 1, "d0_run_a");
    tick(0, 1, 0, 12, 0, 12, 0, 1, 1, "d0_run_b");
    tick(0, 0, 0, 13, 1, 13, 1, 1, 1, "d0_ce_low");

    // dsel=15 clamps to 8.
    tick(0, 1, 15, 1, 1, 1, 1, 1, 1, "d15_edge");
    for (int m = 2; m <= 9; m++) tick(0, 1, 15, 5'(m), 1, 0, 0, 0, 0, "d15_fill");
    for (int m = 10; m <= 14; m++) tick(0, 1, 15, 5'(m), 1, 5'(m - 8), 1, 1, 1, "d15_run");

    // D=4, then mid-stream reset: DEFAULT_DELAY reloads, dsel=4 retakes, 5 edges to valid.
    tick(0, 1, 4, 15, 1, 7, 1, 1, 1, "d4_edge");
    tick(0, 1, 4, 16, 1, 12, 0, 0, 1, "d4_fill_a");
    tick(0, 1, 4, 17, 1, 13, 0, 0, 1, "d4_fill_b");
    tick(0, 1, 4, 18, 1, 14, 0, 0, 1, "d4_fill_c");
    tick(0, 1, 4, 19, 1, 15, 0, 0, 1, "d4_fill_d");
    for (int m = 20; m <= 22; m++) tick(0, 1, 4, 5'(m), 1, 5'(m - 4), 1, 1, 1, "d4_run");
    tick(1, 1, 4, 23, 1, 19, 1, 1, 1, "mid_rst");
    tick(0, 1, 4, 24, 1, 0, 0, 0, 1, "post_rst_a");
    tick(0, 1, 4, 25, 1, 0, 0, 0, 1, "post_rst_b");
    tick(0, 1, 4, 26, 1, 0, 0, 0, 1, "post_rst_c");
    tick(0, 1, 4, 27, 1, 0, 0, 0, 1, "post_rst_d");
    tick(0, 1, 4, 28, 1, 24, 0, 0, 1, "post_rst_e");
    tick(0, 1, 4, 29, 1, 25, 1, 1, 1, "post_rst_run_a");
    tick(0, 1, 4, 30, 1, 26, 1, 1, 1, "post_rst_run_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
